// File: rtl/vga_pixel_fetch.sv
// Fetches VDP lines into ping-pong buffers and emits 2x-scaled RGB in the 640x480 raster.
// Latency: 2 cycles from row/col/HSync/VSync to vga_*; the fetch has one line time (1600 cycles).
// Backpressure: fb_req/fb_addr are held until fb_ack; a fetch that is late at its deadline pulses underrun.
module vga_pixel_fetch #(
    parameter int H_OFF = 64,
    parameter int V_OFF = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        HSync,
    input  logic        VSync,
    input  logic [5:0]  border,
    output logic        fb_req,
    output logic [15:0] fb_addr,
    input  logic        fb_ack,
    input  logic [5:0]  fb_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        underrun
);
    localparam logic [9:0] COL_LO = 10'(H_OFF);
    localparam logic [9:0] COL_HI = 10'(H_OFF + 511);
    localparam logic [8:0] ROW_LO = 9'(V_OFF);
    localparam logic [8:0] ROW_HI = 9'(V_OFF + 383);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       hs_q, vs_q;
    logic       front;
    logic [7:0] line, line_nxt;
    logic [7:0] x, x_nxt;
    logic       underrun_nxt;
    logic       wr_en;

    logic [5:0] buf_a [256];
    logic [5:0] buf_b [256];

    logic       vs_rise, hs_rise;
    logic       row_in;
    logic [8:0] row_rel;
    logic [7:0] n;
    logic       hs_trig, trig_any, start_new;
    logic [7:0] start_line;

    assign vs_rise    = VSync & ~vs_q;
    assign hs_rise    = HSync & ~hs_q;
    assign row_in     = (row >= ROW_LO) && (row <= ROW_HI);
    assign row_rel    = row - ROW_LO;
    assign n          = 8'(row_rel >> 1);
    assign hs_trig    = hs_rise & row_in & ~row_rel[0];
    assign trig_any   = vs_rise | hs_trig;
    assign start_new  = vs_rise | (hs_trig & (n < 8'd191));
    assign start_line = vs_rise ? 8'd0 : n + 8'd1;

    assign fb_req  = (state == REQ);
    assign fb_addr = {line, x};

    // A trigger outranks a coincident ack: the back buffer is about to become
    // the front, so that late pixel must not land in it.
    always_comb begin
        state_nxt    = state;
        line_nxt     = line;
        x_nxt        = x;
        underrun_nxt = 1'b0;
        wr_en        = 1'b0;
        if (trig_any) begin
            underrun_nxt = (state == REQ);
            if (start_new) begin
                state_nxt = REQ;
                line_nxt  = start_line;
                x_nxt     = 8'd0;
            end else begin
                state_nxt = IDLE;
            end
        end else if (state == REQ && fb_ack) begin
            wr_en = 1'b1;
            if (x == 8'd255) begin
                state_nxt = IDLE;
            end else begin
                x_nxt = x + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            front    <= 1'b0;
            line     <= 8'd0;
            x        <= 8'd0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            hs_q     <= HSync;
            vs_q     <= VSync;
            line     <= line_nxt;
            x        <= x_nxt;
            underrun <= underrun_nxt;
            if (hs_trig) begin
                front <= ~front;
            end
        end
    end

    // front == 0 displays A, so fills go to B.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            if (front) begin
                buf_a[x] <= fb_data;
            end else begin
                buf_b[x] <= fb_data;
            end
        end
    end

    logic       s1_win, s1_act, s1_hs, s1_vs;
    logic [7:0] s1_addr;
    logic [5:0] s1_border;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_win    <= 1'b0;
            s1_act    <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_addr   <= 8'd0;
            s1_border <= 6'd0;
        end else begin
            s1_act    <= HSync & VSync;
            s1_win    <= HSync & VSync & row_in & (col >= COL_LO) & (col <= COL_HI);
            s1_addr   <= 8'((col - COL_LO) >> 1);
            s1_hs     <= HSync;
            s1_vs     <= VSync;
            s1_border <= border;
        end
    end

    logic [5:0] pix, colour;

    always_comb begin
        pix    = front ? buf_b[s1_addr] : buf_a[s1_addr];
        colour = 6'd0;
        if (s1_win) begin
            colour = pix;
        end else if (s1_act) begin
            colour = s1_border;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r  <= 4'd0;
            vga_g  <= 4'd0;
            vga_b  <= 4'd0;
            vga_hs <= 1'b0;
            vga_vs <= 1'b0;
        end else begin
            vga_r  <= {colour[1:0], colour[1:0]};
            vga_g  <= {colour[3:2], colour[3:2]};
            vga_b  <= {colour[5:4], colour[5:4]};
            vga_hs <= s1_hs;
            vga_vs <= s1_vs;
        end
    end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: framebuffer model returns x[5:0] ^ line[5:0],
// rows are scanned by hand and outputs captured per column for later checking.
module tb_vga_pixel_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        HSync, VSync;
    logic [5:0]  border;
    logic        fb_req;
    logic [15:0] fb_addr;
    logic        fb_ack;
    logic [5:0]  fb_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, underrun;

    int   asserts  = 0;
    int   failures = 0;
    int   mode     = 3;   // 1: ack tied to req, 2: fixed latency, 3: manual
    int   lat      = 10;
    int   cnt      = 0;
    logic ack_man  = 1'b0;
    logic ack_r    = 1'b0;

    logic [11:0] cap_rgb  [640];
    logic        cap_hs   [640];
    logic        cap_req  [640];
    logic [15:0] cap_addr [640];
    logic        cap_und  [640];

    vga_pixel_fetch #(.H_OFF(64), .V_OFF(48)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .HSync(HSync), .VSync(VSync),
        .border(border), .fb_req(fb_req), .fb_addr(fb_addr), .fb_ack(fb_ack),
        .fb_data(fb_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .underrun(underrun)
    );

    always #5 clk = ~clk;

    assign fb_ack  = (mode == 1) ? fb_req : (mode == 2) ? ack_r : ack_man;
    assign fb_data = fb_addr[5:0] ^ fb_addr[13:8];

    always @(negedge clk) begin
        if (mode != 2 || ack_r) begin
            ack_r = 1'b0;
            cnt   = 0;
        end else if (fb_req) begin
            cnt = cnt + 1;
            if (cnt >= lat) ack_r = 1'b1;
        end else begin
            cnt = 0;
        end
    end

    task automatic scan_row(input logic [8:0] r, input int ncols);
        HSync = 1'b0; row = r; col = 10'd0;
        @(negedge clk); @(negedge clk);
        HSync = 1'b1;
        for (int k = 1; k <= ncols + 1; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                cap_rgb[k-2] = {vga_b, vga_g, vga_r};
                cap_hs[k-2]  = vga_hs;
            end
            cap_req[k-1]  = fb_req;
            cap_addr[k-1] = fb_addr;
            cap_und[k-1]  = underrun;
            col = 10'(k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; row = 9'd48; col = 10'd70; HSync = 1'b1; VSync = 1'b1;
        border = 6'b110000;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ack_man = ~ack_man;
            asserts++;
            if ({fb_req, underrun, vga_hs, vga_vs} !== 4'b0000 || {vga_b, vga_g, vga_r} !== 12'h000) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: req=%b und=%b hs=%b vs=%b rgb=%h, required all 0",
                         i, fb_req, underrun, vga_hs, vga_vs, {vga_b, vga_g, vga_r});
            end
        end
        row = 9'd0; col = 10'd0; HSync = 1'b0; VSync = 1'b0; ack_man = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        int bad = 0;
        int first_bad = -1;
        mode = 1;
        VSync = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (fb_req !== 1'b1 || fb_addr !== 16'(k - 1)) begin
                if (first_bad < 0) first_bad = k - 1;
                bad++;
            end
        end
        asserts++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL zw_line0_addrs: %0d bad cycles, first at x=%0d; required 0 bad", bad, first_bad);
        end
        @(negedge clk);
        asserts++;
        if (fb_req !== 1'b0) begin
            failures++;
            $display("FAIL zw_line0_idle: fb_req=%b, required 0", fb_req);
        end
        scan_row(9'd48, 590);
        bad = 0; first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (cap_req[i] !== 1'b1 || cap_addr[i] !== 16'h0100 + 16'(i)) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        asserts++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL zw_line1_addrs: %0d bad cycles, first at x=%0d; required 0 bad", bad, first_bad);
        end
        asserts++;
        if (cap_req[256] !== 1'b0) begin
            failures++;
            $display("FAIL zw_line1_idle: fb_req=%b, required 0", cap_req[256]);
        end
    endtask

    task automatic test_scaling();
        int          cols [7] = '{63, 64, 65, 66, 154, 575, 576};
        logic [11:0] exp  [7] = '{12'hF00, 12'h000, 12'h000, 12'h005, 12'hAF5, 12'hFFF, 12'hF00};
        for (int i = 0; i < 7; i++) begin
            asserts++;
            if (cap_rgb[cols[i]] !== exp[i]) begin
                failures++;
                $display("FAIL scale_row48 col %0d: bgr=%h, required %h", cols[i], cap_rgb[cols[i]], exp[i]);
            end
        end
        scan_row(9'd50, 80);
        asserts++;
        if (cap_addr[0] !== 16'h0200 || cap_req[0] !== 1'b1) begin
            failures++;
            $display("FAIL row50_fetch: req=%b addr=%h, required 1 0200", cap_req[0], cap_addr[0]);
        end
        asserts++;
        if ({cap_rgb[64], cap_rgb[66], cap_rgb[68]} !== {12'h005, 12'h000, 12'h00F}) begin
            failures++;
            $display("FAIL row50_toggle: bgr=%h %h %h, required 005 000 00f", cap_rgb[64], cap_rgb[66], cap_rgb[68]);
        end
        repeat (300) @(negedge clk);
    endtask

    task automatic test_border_blank();
        scan_row(9'd10, 20);
        asserts++;
        if (cap_rgb[10] !== 12'hF00 || cap_hs[10] !== 1'b1) begin
            failures++;
            $display("FAIL border_col10: bgr=%h hs=%b, required f00 1", cap_rgb[10], cap_hs[10]);
        end
        HSync = 1'b0;
        @(negedge clk);
        asserts++;
        if (vga_hs !== 1'b1) begin
            failures++;
            $display("FAIL hs_lag1: vga_hs=%b, required 1", vga_hs);
        end
        @(negedge clk);
        asserts++;
        if (vga_hs !== 1'b0 || vga_vs !== 1'b1 || {vga_b, vga_g, vga_r} !== 12'h000) begin
            failures++;
            $display("FAIL blank: hs=%b vs=%b bgr=%h, required 0 1 000", vga_hs, vga_vs, {vga_b, vga_g, vga_r});
        end
    endtask

    task automatic test_underrun();
        mode = 2;
        scan_row(9'd52, 40);
        asserts++;
        if (cap_addr[0] !== 16'h0300 || cap_und[0] !== 1'b0) begin
            failures++;
            $display("FAIL und_start: addr=%h und=%b, required 0300 0", cap_addr[0], cap_und[0]);
        end
        asserts++;
        if (cap_addr[39][15:8] !== 8'h03 || cap_addr[39][7:0] < 8'd2 || cap_addr[39][7:0] > 8'd4) begin
            failures++;
            $display("FAIL und_progress: addr=%h, required line 03 with x near 3", cap_addr[39]);
        end
        scan_row(9'd54, 4);
        asserts++;
        if (cap_und[0] !== 1'b1 || cap_addr[0] !== 16'h0400 || cap_req[0] !== 1'b1) begin
            failures++;
            $display("FAIL und_hs: und=%b addr=%h req=%b, required 1 0400 1", cap_und[0], cap_addr[0], cap_req[0]);
        end
        asserts++;
        if (cap_und[1] !== 1'b0) begin
            failures++;
            $display("FAIL und_hs_pulse: und=%b one cycle later, required 0", cap_und[1]);
        end
        HSync = 1'b0; VSync = 1'b0; row = 9'd0; col = 10'd0;
        @(negedge clk); @(negedge clk);
        VSync = 1'b1;
        @(negedge clk);
        asserts++;
        if (underrun !== 1'b1 || fb_addr !== 16'h0000 || fb_req !== 1'b1) begin
            failures++;
            $display("FAIL und_vs: und=%b addr=%h req=%b, required 1 0000 1", underrun, fb_addr, fb_req);
        end
        @(negedge clk);
        asserts++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL und_vs_pulse: und=%b, required 0", underrun);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int guard = 0;
        mode = 3; ack_man = 1'b0;
        while (fb_addr[7:0] !== 8'd100 && guard < 300) begin
            ack_man = 1'b1;
            @(negedge clk);
            guard++;
        end
        ack_man = 1'b0;
        asserts++;
        if (fb_addr !== 16'h0064 || fb_req !== 1'b1) begin
            failures++;
            $display("FAIL rmf_reach_x100: addr=%h req=%b, required 0064 1", fb_addr, fb_req);
        end
        rst = 1'b1; HSync = 1'b0; VSync = 1'b0;
        @(negedge clk);
        rst = 1'b0; ack_man = 1'b1;
        asserts++;
        if (fb_req !== 1'b0 || fb_addr !== 16'h0000 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL rmf_drop: req=%b addr=%h und=%b, required 0 0000 0", fb_req, fb_addr, underrun);
        end
        @(negedge clk);
        ack_man = 1'b0;
        asserts++;
        if (fb_req !== 1'b0 || fb_addr !== 16'h0000) begin
            failures++;
            $display("FAIL rmf_late_ack: req=%b addr=%h, required 0 0000", fb_req, fb_addr);
        end
        VSync = 1'b1;
        @(negedge clk);
        asserts++;
        if (fb_req !== 1'b1 || fb_addr !== 16'h0000 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL rmf_restart: req=%b addr=%h und=%b, required 1 0000 0", fb_req, fb_addr, underrun);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_scaling();
        test_border_blank();
        test_underrun();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Pixel-fetch and scaling stage that sits directly downstream of the VGA timing generator. It consumes the generator's `row`, `col`, `HSync` and `VSync`, and fetches the 256x192 VDP frame line by line from the framebuffer over a req/ack handshake into ping-pong line buffers. It outputs 2x-scaled RGB centred in the 640x480 raster, with a border colour around the image and black during blanking.

## Interface
- `H_OFF`, default 64: first VGA column of the image window.
- `V_OFF`, default 48: first VGA row of the image window.
- `clk` input 1: system/pixel clock, the same clock as the timing generator.
- `rst` input 1: synchronous, active-high reset.
- `row` input 9: visible row, 0..479, from the timing generator.
- `col` input 10: visible column, 0..639, from the timing generator.
- `HSync` input 1: timing generator HSync; high during active columns.
- `VSync` input 1: timing generator VSync; high during active rows.
- `border` input 6: border colour, format `{b[1:0],g[1:0],r[1:0]}`.
- `fb_req` output 1: framebuffer read request.
- `fb_addr` output 16: framebuffer address, `{line[7:0], x[7:0]}`.
- `fb_ack` input 1: framebuffer acknowledge; `fb_data` is valid in this cycle.
- `fb_data` input 6: pixel colour, same format as `border`.
- `vga_r`, `vga_g`, `vga_b` output 4 each: colour channels.
- `vga_hs`, `vga_vs` output 1 each: `HSync`/`VSync` delayed to align with the colour outputs.
- `underrun` output 1: one-cycle pulse when a line fetch is not finished by the time it is needed.

## Operation
- **Line buffers.** Two 256x6 buffers, A and B. `front` selects the one being displayed; the other is the fill target. `front` resets to A.
- **Edge detect.** `HSync` and `VSync` are registered to detect rising edges.
  - `vs_rise` = frame start.
  - `hs_rise` = start of a visible row.
- **Fetch triggers.**
  - `vs_rise`: start fetching VDP line 0 into the back buffer.
  - `hs_rise` when `row` is in [V_OFF, V_OFF+383] and (`row`−V_OFF) is even: first, toggle `front`. Then, if n = (`row`−V_OFF)>>1 is below 191, start fetching line n+1 into the new back buffer.
- **Fetch FSM.**
  - IDLE: `fb_req`=0. On a trigger, load `line`, set `x`=0, go to REQ.
  - REQ: `fb_req`=1, `fb_addr`={line,x}, both held stable until `fb_ack`.
  - On `fb_ack`: write `fb_data` to back[x]. If `x`=255, go to IDLE; otherwise increment `x` and stay in REQ, so a new request may be issued on the very next cycle.
  - Exactly one acknowledged transfer per pixel. `fb_ack` is ignored while in IDLE.
- **Underrun.** A trigger that arrives while in REQ pulses `underrun` for one cycle, abandons the current fetch, and restarts with the new line at `x`=0. The buffer toggle on that `hs_rise` still happens.
- **Display path.**
  - The pixel is in the window when `HSync` && `VSync`, `col` is in [H_OFF, H_OFF+511] and `row` is in [V_OFF, V_OFF+383].
  - Read address = (`col`−H_OFF)>>1.
  - Output colour:
    - in window: front[addr];
    - otherwise, if `HSync` && `VSync`: `border`;
    - otherwise: 0.
  - Each 2-bit channel c expands to 4 bits as {c,c}. For example, 2'b10 becomes 4'b1010.
- **Reset.**
  - All outputs are 0 and the FSM is in IDLE.
  - A reset mid-fetch drops `fb_req` on that edge; a late `fb_ack` afterwards is ignored.
  - Buffer contents are not cleared.

## Timing
- Display latency is 2 cycles from `row`/`col`/`HSync`/`VSync` to `vga_*`:
  - stage 1: registered window flag, address and sync;
  - stage 2: synchronous buffer read and colour mux into the output registers.
- `vga_hs`/`vga_vs` equal `HSync`/`VSync` delayed 2 cycles.
- The `front` toggle on `hs_rise` takes effect before the first in-window column of that row, since H_OFF ≥ 2.
- The fetch budget is 1600 cycles per line (two VGA rows). 256 pixels fit if the mean `fb_ack` latency is 5 cycles or less.
- The line 0 fetch has V_OFF×800 cycles available.
- If a back-buffer write and a front-buffer read hit the same cycle, they are in different buffers, so there is no conflict.

## Test plan
- **Reset.** Hold `rst` for 3 cycles with `fb_ack` toggling → `fb_req`=0, all `vga_*`=0, `underrun`=0 throughout.
- **Zero-wait fetch.** `fb_ack` tied to `fb_req` → after `vs_rise`, 256 requests with `fb_addr` 0x0000..0x00FF, FSM back in IDLE 256 cycles later. At row 48, `hs_rise` triggers a fetch of 0x0100..0x01FF.
- **Scaling and colour.** Framebuffer pixel = x[5:0]; at row 48, col 64 and col 65 → {`vga_b`,`vga_g`,`vga_r`}=0 two cycles later. At col 66 → `vga_r`=4'b0101, `vga_g`=0, `vga_b`=0.
- **Border and blank.** `border`=6'b110000, at col 10, row 10 → `vga_b`=4'hF, `vga_r`=`vga_g`=0. With `HSync`=0 → all channels 0, and `vga_hs` follows `HSync` with a 2-cycle lag.
- **Underrun.** `fb_ack` latency 10 cycles → `underrun` pulses once at each trigger; the fetch restarts at `x`=0 with the new line address.
- **Reset mid-fetch.** Assert `rst` with `x`=100 in REQ, then deliver `fb_ack` one cycle after → no buffer write, `fb_req`=0, the next `vs_rise` restarts at 0x0000.
